mesh_phase_sequencer: RTL and testbench
=======================================

Name: mesh_phase_sequencer

Overview:
- Central controller for the N-PE sorting mesh. It generates the global operation and phase schedule (PUSH_ADDR / GET_DATA / COMPUTE × SORT / ROW_ALIGN / COL_ALIGN / NOP) and broadcasts it to every PE.
- It also drives the per-step compare-exchange controls during SORT, so PEs need no private schedule counters.
- Started by a host pulse. It runs ITERATIONS full rounds, then signals done.

Parameters:
- SQRT_N, 32: mesh side length; must be a power of two, ≥ 2.
- SORT_CYCLES, 222: last step index of a SORT phase; SORT lasts SORT_CYCLES+1 cycles.
- COMPUTE_CYCLES, 3: last step index of the NOP phase; NOP lasts COMPUTE_CYCLES+1 cycles.
- ITERATIONS, 1: number of PUSH_ADDR→GET_DATA→COMPUTE rounds per start; ≥ 1.
- CNT_WIDTH, 16: step counter width; must hold max(SORT_CYCLES, SQRT_N, COMPUTE_CYCLES).
- ITER_WIDTH, 8: iteration counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin schedule; single-cycle pulse, sampled only in IDLE
- hold  in  1  freeze every register while high
- o_op  out  2  00 PUSH_ADDR, 01 GET_DATA, 10 COMPUTE, 11 IDLE
- o_phase  out  3  000 SORT, 001 ROW_ALIGN, 010 COL_ALIGN, 111 NOP
- o_step  out  CNT_WIDTH  step index within the current phase
- o_last  out  1  high on the final step of the current phase
- o_cx_vert  out  1  SORT only: 0 = row (horizontal) compare-exchange, 1 = column (vertical)
- o_cx_odd  out  1  SORT only: 0 = even pairs, 1 = odd pairs
- o_iter  out  ITER_WIDTH  completed-iteration count
- o_busy  out  1  high from the first active cycle to the last NOP cycle
- o_done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset values: o_op=11, o_phase=111, o_step=0, o_last=0, o_cx_vert=0, o_cx_odd=0, o_iter=0, o_busy=0, o_done=0.
- rst mid-operation aborts immediately to the reset values. There is no done pulse.
- IDLE: if start=1 and hold=0 at an edge, the next cycle shows op=PUSH_ADDR, phase=SORT, step=0, busy=1, iter=0.
- start while busy is ignored.
- Registered outputs only. Each phase occupies exactly (limit+1) cycles, with step running 0..limit:
  - SORT: limit = SORT_CYCLES
  - ROW_ALIGN, COL_ALIGN: limit = SQRT_N
  - NOP: limit = COMPUTE_CYCLES
- Step counter clears on every phase change. o_last = (step == limit).
- Transitions are taken when o_last=1 and hold=0:
  - SORT → ROW_ALIGN → COL_ALIGN.
  - COL_ALIGN in PUSH_ADDR → op=GET_DATA, phase=SORT.
  - COL_ALIGN in GET_DATA → op=COMPUTE, phase=NOP.
  - NOP end: iter increments.
    - If new iter == ITERATIONS: go to IDLE (op=11, phase=111, busy=0) with done=1 for that one cycle.
    - Otherwise: op=PUSH_ADDR, phase=SORT.
- Compare-exchange during SORT:
  - o_cx_odd = step[0].
  - o_cx_vert = bit log2(SQRT_N) of step, i.e. alternating row and column passes of SQRT_N steps each.
  - Both are 0 in every other phase and in IDLE.
- hold=1 freezes state, step, iter and all outputs. A done pulse cannot be stretched: done is registered only on the transition edge, which requires hold=0.
- hold and start in the same IDLE cycle: start is lost (hold has priority).
- Counters are CNT_WIDTH-wide with no wrap in legal configs. An elaboration-time check fails if any limit ≥ 2^CNT_WIDTH or ITERATIONS ≥ 2^ITER_WIDTH.

Decomposition:
- Shared package mesh_pkg holds:
  - op encodings (PUSH_ADDR, GET_DATA, COMPUTE, OP_IDLE)
  - phase encodings (SORT, ROW_ALIGN, COL_ALIGN, NOP)
  - the PE state-field bit positions
- PEs and this sequencer import it.
- One sub-module, phase_step_counter: synchronous clear, enable, and a terminal-compare output.
- The op/phase FSM and iteration counter stay in the top module.

Test Plan:
All scenarios use SQRT_N=4, SORT_CYCLES=10, COMPUTE_CYCLES=3, ITERATIONS=2, with the start edge at cycle 0.
1. Single start, hold=0:
   - cycles 1–11 SORT, 12–16 ROW_ALIGN, 17–21 COL_ALIGN under PUSH_ADDR
   - cycles 22–42 repeat the same phases under GET_DATA
   - cycles 43–46 COMPUTE/NOP, with o_iter=1 at cycle 47
   - second round runs cycles 47–92, then IDLE and o_done=1 at cycle 93, o_busy=0
2. SORT compare-exchange signals, round 1:
   - o_cx_odd toggles 0,1,0,1,…
   - o_cx_vert = 0 for steps 0–3, 1 for steps 4–7, 0 for steps 8–10
   - both are 0 at cycle 12
3. hold=1 for cycles 15–19:
   - phase=ROW_ALIGN and step=3 stay frozen through cycle 20
   - the whole schedule and o_done shift by 5 cycles (done at cycle 98)
4. start re-pulsed at cycle 30 (while busy) -> no effect; done still at cycle 93.
   start pulsed at cycle 93 (IDLE) -> new run with busy=1 at cycle 94.
5. rst at cycle 25 -> at cycle 26 all outputs equal reset values and o_done stays 0.
   start at cycle 30 -> restart from PUSH_ADDR/SORT step 0 with iter=0.
6. start and hold both high in IDLE -> remains IDLE; no busy, no done.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared encodings for the sorting mesh: global op, phase, and the bit
// positions of the broadcast fields inside a PE state word.
package mesh_pkg;

    typedef enum logic [1:0] {
        PUSH_ADDR = 2'b00,
        GET_DATA  = 2'b01,
        COMPUTE   = 2'b10,
        OP_IDLE   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        SORT      = 3'b000,
        ROW_ALIGN = 3'b001,
        COL_ALIGN = 3'b010,
        NOP       = 3'b111
    } phase_e;

    // PE state-field layout: {cx_odd, cx_vert, phase[2:0], op[1:0]}
    localparam int PE_ST_OP_LSB      = 0;
    localparam int PE_ST_OP_MSB      = 1;
    localparam int PE_ST_PHASE_LSB   = 2;
    localparam int PE_ST_PHASE_MSB   = 4;
    localparam int PE_ST_CX_VERT_BIT = 5;
    localparam int PE_ST_CX_ODD_BIT  = 6;
    localparam int PE_ST_WIDTH       = 7;

endpackage

// File: rtl/mesh_phase_sequencer_if.sv
// Host control and schedule broadcast bundle for the mesh phase sequencer.
// master = the sequencer; slave = host / PE side.
interface mesh_phase_sequencer_if #(
    parameter int CNT_WIDTH  = 16,
    parameter int ITER_WIDTH = 8
);
    logic                  start;
    logic                  hold;
    logic [1:0]            o_op;
    logic [2:0]            o_phase;
    logic [CNT_WIDTH-1:0]  o_step;
    logic                  o_last;
    logic                  o_cx_vert;
    logic                  o_cx_odd;
    logic [ITER_WIDTH-1:0] o_iter;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  start, hold,
        output o_op, o_phase, o_step, o_last, o_cx_vert, o_cx_odd,
               o_iter, o_busy, o_done
    );

    modport slave (
        output start, hold,
        input  o_op, o_phase, o_step, o_last, o_cx_vert, o_cx_odd,
               o_iter, o_busy, o_done
    );
endinterface

// File: rtl/phase_step_counter.sv
// Step counter for one phase: synchronous clear wins over enable; term_o
// flags that the count has reached the current phase limit.
module phase_step_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 term_o
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear on phase change, advance when enabled, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == limit_i);
endmodule

// File: rtl/mesh_phase_sequencer.sv
// Global op/phase scheduler for the N-PE sorting mesh. Walks
// PUSH_ADDR{SORT,ROW,COL} -> GET_DATA{SORT,ROW,COL} -> COMPUTE{NOP} for
// ITERATIONS rounds per start, and drives the SORT compare-exchange pattern.
module mesh_phase_sequencer
    import mesh_pkg::*;
#(
    parameter int SQRT_N         = 32,
    parameter int SORT_CYCLES    = 222,
    parameter int COMPUTE_CYCLES = 3,
    parameter int ITERATIONS     = 1,
    parameter int CNT_WIDTH      = 16,
    parameter int ITER_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mesh_phase_sequencer_if.master bus
);
    localparam int LOG2N = $clog2(SQRT_N);

    // Elaboration guards: the counters never wrap in a legal configuration.
    generate
        if (SQRT_N < 2 || (SQRT_N & (SQRT_N - 1)) != 0) begin : g_bad_sqrt_n
            $error("mesh_phase_sequencer: SQRT_N must be a power of two >= 2");
        end
        if ((SORT_CYCLES >> CNT_WIDTH) != 0 || (SQRT_N >> CNT_WIDTH) != 0 ||
            (COMPUTE_CYCLES >> CNT_WIDTH) != 0) begin : g_bad_cnt_width
            $error("mesh_phase_sequencer: a phase limit does not fit CNT_WIDTH");
        end
        if (ITERATIONS < 1 || (ITERATIONS >> ITER_WIDTH) != 0) begin : g_bad_iter
            $error("mesh_phase_sequencer: ITERATIONS must be >= 1 and fit ITER_WIDTH");
        end
    endgenerate

    op_e                   op_q, op_d;
    phase_e                phase_q, phase_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [CNT_WIDTH-1:0]  step;
    logic [CNT_WIDTH-1:0]  limit;
    logic                  term;
    logic                  last;
    logic                  step_clr;
    logic                  step_en;

    phase_step_counter #(.CNT_WIDTH(CNT_WIDTH)) u_step (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (step_clr),
        .en_i    (step_en),
        .limit_i (limit),
        .cnt_o   (step),
        .term_o  (term)
    );

    // Last step index of the phase currently being executed.
    always_comb begin
        limit = CNT_WIDTH'(COMPUTE_CYCLES);
        case (phase_q)
            SORT:                 limit = CNT_WIDTH'(SORT_CYCLES);
            ROW_ALIGN, COL_ALIGN: limit = CNT_WIDTH'(SQRT_N);
            default:              limit = CNT_WIDTH'(COMPUTE_CYCLES);
        endcase
    end

    // IDLE reuses the NOP phase code, so gate the terminal compare with busy.
    assign last = busy_q & term;

    // Schedule next-state: hold freezes everything; done is only ever set on
    // the unheld transition edge, so it can never be stretched.
    always_comb begin
        op_d     = op_q;
        phase_d  = phase_q;
        iter_d   = iter_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        step_clr = 1'b0;
        step_en  = 1'b0;
        if (!bus.hold) begin
            if (!busy_q) begin
                if (bus.start) begin
                    op_d     = PUSH_ADDR;
                    phase_d  = SORT;
                    iter_d   = '0;
                    busy_d   = 1'b1;
                    step_clr = 1'b1;
                end
            end else if (last) begin
                step_clr = 1'b1;
                case (phase_q)
                    SORT:      phase_d = ROW_ALIGN;
                    ROW_ALIGN: phase_d = COL_ALIGN;
                    COL_ALIGN: begin
                        if (op_q == PUSH_ADDR) begin
                            op_d    = GET_DATA;
                            phase_d = SORT;
                        end else begin
                            op_d    = COMPUTE;
                            phase_d = NOP;
                        end
                    end
                    default: begin
                        iter_d = iter_q + ITER_WIDTH'(1);
                        if (iter_d == ITER_WIDTH'(ITERATIONS)) begin
                            op_d    = OP_IDLE;
                            phase_d = NOP;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            op_d    = PUSH_ADDR;
                            phase_d = SORT;
                        end
                    end
                endcase
            end else begin
                step_en = 1'b1;
            end
        end
    end

    // Schedule state registers; reset aborts straight to IDLE with no done.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_IDLE;
            phase_q <= NOP;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            phase_q <= phase_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_op      = op_q;
    assign bus.o_phase   = phase_q;
    assign bus.o_step    = step;
    assign bus.o_last    = last;
    assign bus.o_cx_odd  = busy_q && (phase_q == SORT) && step[0];
    assign bus.o_cx_vert = busy_q && (phase_q == SORT) && step[LOG2N];
    assign bus.o_iter    = iter_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
endmodule

// File: tb/tb_mesh_phase_sequencer.sv
// Bench for mesh_phase_sequencer: a position-in-run model (cycles elapsed in
// the current run) predicts every output; literal checks pin the schedule.
module tb_mesh_phase_sequencer;
    localparam int SN = 4;
    localparam int SC = 10;
    localparam int CC = 3;
    localparam int IT = 2;
    localparam int CW = 16;
    localparam int IW = 8;
    // Cycles per round: two address/data passes of SORT+ROW+COL, then NOP.
    localparam int RL = 2 * ((SC + 1) + 2 * (SN + 1)) + (CC + 1);

    logic clk;
    logic rst;
    mesh_phase_sequencer_if #(.CNT_WIDTH(CW), .ITER_WIDTH(IW)) bus ();

    mesh_phase_sequencer #(
        .SQRT_N(SN), .SORT_CYCLES(SC), .COMPUTE_CYCLES(CC),
        .ITERATIONS(IT), .CNT_WIDTH(CW), .ITER_WIDTH(IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rel     = 0;
    bit chk_en  = 1'b0;

    // model state
    bit m_busy = 1'b0;
    int m_t    = 0;
    int m_iter = 0;
    bit m_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, rel, act, exp);
        end
    endtask

    task automatic model_update(input bit st, input bit hd, input bit rs);
        if (rs) begin
            m_busy = 1'b0; m_t = 0; m_iter = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!hd) begin
                if (!m_busy) begin
                    if (st) begin
                        m_busy = 1'b1; m_t = 0; m_iter = 0;
                    end
                end else begin
                    m_t++;
                    if (m_t == IT * RL) begin
                        m_busy = 1'b0; m_done = 1'b1; m_iter = IT; m_t = 0;
                    end
                end
            end
        end
    endtask

    task automatic model_out(output int op, output int ph, output int st,
                             output int lst, output int cv, output int co,
                             output int it);
        int lim[7];
        int ops[7];
        int phs[7];
        int r;
        bit found;
        lim = '{SC, SN, SN, SC, SN, SN, CC};
        ops = '{0, 0, 0, 1, 1, 1, 2};
        phs = '{0, 1, 2, 0, 1, 2, 7};
        op = 3; ph = 7; st = 0; lst = 0; cv = 0; co = 0; it = m_iter;
        if (m_busy) begin
            it = m_t / RL;
            r = m_t % RL;
            found = 1'b0;
            for (int k = 0; k < 7; k++) begin
                if (!found) begin
                    if (r <= lim[k]) begin
                        found = 1'b1;
                        op = ops[k]; ph = phs[k]; st = r;
                        lst = (r == lim[k]) ? 1 : 0;
                        if (ph == 0) begin
                            co = r % 2;
                            cv = (r / SN) % 2;
                        end
                    end else begin
                        r -= lim[k] + 1;
                    end
                end
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int e_op, e_ph, e_st, e_lst, e_cv, e_co, e_it;
        if (chk_en) begin
            model_out(e_op, e_ph, e_st, e_lst, e_cv, e_co, e_it);
            chk("op",      int'(bus.o_op),      e_op);
            chk("phase",   int'(bus.o_phase),   e_ph);
            chk("step",    int'(bus.o_step),    e_st);
            chk("last",    int'(bus.o_last),    e_lst);
            chk("cx_vert", int'(bus.o_cx_vert), e_cv);
            chk("cx_odd",  int'(bus.o_cx_odd),  e_co);
            chk("iter",    int'(bus.o_iter),    e_it);
            chk("busy",    int'(bus.o_busy),    int'(m_busy));
            chk("done",    int'(bus.o_done),    int'(m_done));
        end
    end

    task automatic tick(input bit st, input bit hd, input bit rs);
        bus.start = st;
        bus.hold  = hd;
        rst       = rs;
        @(posedge clk);
        model_update(st, hd, rs);
        rel++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b1);
        rel = 0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        tick(1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        chk("rst_op",    int'(bus.o_op), 3);
        chk("rst_phase", int'(bus.o_phase), 7);
        chk("rst_busy",  int'(bus.o_busy), 0);
        chk("rst_iter",  int'(bus.o_iter), 0);

        // Single start, no hold; compare-exchange pattern in round 1.
        rel = 0;
        while (rel < 95) begin
            tick(rel == 0, 1'b0, 1'b0);
            if (rel == 1)  chk("s1_busy_on", int'(bus.o_busy), 1);
            if (rel >= 1 && rel <= 11) begin
                chk("s2_cx_odd",  int'(bus.o_cx_odd), (rel - 1) % 2);
                chk("s2_cx_vert", int'(bus.o_cx_vert), (rel >= 5 && rel <= 8) ? 1 : 0);
            end
            if (rel == 11) chk("s1_sort_last", int'(bus.o_last), 1);
            if (rel == 12) begin
                chk("s1_row_phase", int'(bus.o_phase), 1);
                chk("s2_cx_off",    int'(bus.o_cx_vert) + int'(bus.o_cx_odd), 0);
            end
            if (rel == 22) chk("s1_get_data", int'(bus.o_op), 1);
            if (rel == 43) chk("s1_nop",      int'(bus.o_phase), 7);
            if (rel == 47) chk("s1_iter1",    int'(bus.o_iter), 1);
            if (rel == 92) chk("s1_done_early", int'(bus.o_done), 0);
            if (rel == 93) begin
                chk("s1_done",   int'(bus.o_done), 1);
                chk("s1_busy_0", int'(bus.o_busy), 0);
                chk("s1_iter2",  int'(bus.o_iter), 2);
            end
            if (rel == 94) chk("s1_done_pulse", int'(bus.o_done), 0);
        end

        // Hold for cycles 15..19 shifts everything by 5.
        do_reset();
        while (rel < 100) begin
            tick(rel == 0, rel >= 15 && rel <= 19, 1'b0);
            if (rel >= 15 && rel <= 20) begin
                chk("s3_frozen_phase", int'(bus.o_phase), 1);
                chk("s3_frozen_step",  int'(bus.o_step), 3);
            end
            if (rel == 93) chk("s3_no_done_93", int'(bus.o_done), 0);
            if (rel == 98) chk("s3_done_98",    int'(bus.o_done), 1);
        end

        // Start while busy is ignored; start in IDLE relaunches.
        do_reset();
        while (rel < 96) begin
            tick(rel == 0 || rel == 30 || rel == 93, 1'b0, 1'b0);
            if (rel == 93) chk("s4_done_93", int'(bus.o_done), 1);
            if (rel == 94) begin
                chk("s4_busy_94", int'(bus.o_busy), 1);
                chk("s4_op_94",   int'(bus.o_op), 0);
                chk("s4_iter_94", int'(bus.o_iter), 0);
            end
        end

        // Reset mid-run, then restart.
        do_reset();
        while (rel < 40) begin
            tick(rel == 0 || rel == 30, 1'b0, rel == 25);
            if (rel == 26) begin
                chk("s5_op",    int'(bus.o_op), 3);
                chk("s5_phase", int'(bus.o_phase), 7);
                chk("s5_step",  int'(bus.o_step), 0);
                chk("s5_iter",  int'(bus.o_iter), 0);
                chk("s5_busy",  int'(bus.o_busy), 0);
            end
            if (rel >= 26 && rel <= 30) chk("s5_no_done", int'(bus.o_done), 0);
            if (rel == 31) begin
                chk("s5_restart_op",   int'(bus.o_op), 0);
                chk("s5_restart_ph",   int'(bus.o_phase), 0);
                chk("s5_restart_step", int'(bus.o_step), 0);
                chk("s5_restart_busy", int'(bus.o_busy), 1);
            end
        end

        // start with hold in IDLE is lost.
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("s6_busy", int'(bus.o_busy), 0);
            chk("s6_done", int'(bus.o_done), 0);
            chk("s6_op",   int'(bus.o_op), 3);
            tick(1'b0, 1'b0, 1'b0);
        end

        // Randomized start/hold/reset against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 16) == 0, ($urandom % 5) == 0, ($urandom % 500) == 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
